// File: rtl/midi_voice_alloc.sv
// MIDI voice allocator: decodes USB-MIDI event packets and maintains a
// polyphonic voice table (retrigger / free / oldest-steal) feeding the synth.
// Each accepted event takes NUM_VOICES scan cycles plus one commit cycle.
// VOICE_TRIG is registered: it is high in the cycle after the commit edge,
// aligned with the gate/note/velocity update it accompanies.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [3:0]              CHANNEL,
  input  logic                    OMNI,
  input  logic [31:0]             EVT_DATA,
  input  logic                    EVT_VALID,
  output logic                    EVT_READY,
  output logic [NUM_VOICES-1:0]   VOICE_GATE,
  output logic [7*NUM_VOICES-1:0] VOICE_NOTE,
  output logic [7*NUM_VOICES-1:0] VOICE_VEL,
  output logic [NUM_VOICES-1:0]   VOICE_TRIG,
  output logic [13:0]             PITCH_BEND,
  output logic                    SUSTAIN,
  output logic [7:0]              STEAL_CNT
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_nxt;

  logic [IDX_W-1:0] idx;
  logic [27:0]      pkt;

  // Voice table
  logic [NUM_VOICES-1:0] gate, held, trig;
  logic [6:0]            note [NUM_VOICES];
  logic [6:0]            vel  [NUM_VOICES];
  logic [AGE_W-1:0]      age  [NUM_VOICES];

  // Scan results
  logic             match_found, free_found, old_found;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx, tgt;
  logic [AGE_W-1:0] old_age;
  logic             steal;

  // Decode of the latched packet (cable number is not needed)
  logic [3:0] cin, typ, chn;
  logic [7:0] d1, d2;
  logic       chan_ok, is_on, is_off, is_cc, is_bend, sus_new;
  logic       unused_hdr;

  assign unused_hdr = ^EVT_DATA[31:28];
  assign cin     = pkt[27:24];
  assign typ     = pkt[23:20];
  assign chn     = pkt[19:16];
  assign d1      = pkt[15:8];
  assign d2      = pkt[7:0];
  assign chan_ok = OMNI || (chn == CHANNEL);
  assign is_on   = chan_ok && cin == 4'h9 && typ == 4'h9 && d2 != 8'd0;
  assign is_off  = chan_ok && ((cin == 4'h8 && typ == 4'h8) ||
                               (cin == 4'h9 && typ == 4'h9 && d2 == 8'd0));
  assign is_cc   = chan_ok && cin == 4'hB && typ == 4'hB;
  assign is_bend = chan_ok && cin == 4'hE && typ == 4'hE;
  assign sus_new = (d2 >= 8'd64);

  assign EVT_READY  = (state == IDLE);
  assign VOICE_GATE = gate;
  assign VOICE_TRIG = trig;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign VOICE_NOTE[7*g +: 7] = note[g];
    assign VOICE_VEL[7*g +: 7]  = vel[g];
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: accept, scan every voice once, commit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (EVT_VALID) state_nxt = SCAN;
      SCAN:    if (idx == LAST_IDX) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Commit target: retrigger beats free voice beats steal of the oldest
  always_comb begin
    tgt   = old_idx;
    steal = 1'b0;
    if (match_found)     tgt = match_idx;
    else if (free_found) tgt = free_idx;
    else                 steal = 1'b1;
  end

  // Packet latch and per-voice scan, lowest index wins every tie
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pkt         <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (state == IDLE && EVT_VALID) begin
      pkt         <= EVT_DATA[27:0];
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
    end else if (state == SCAN) begin
      if (gate[idx] && note[idx] == d1[6:0] && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!gate[idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      if (gate[idx] && (!old_found || age[idx] > old_age)) begin
        old_found <= 1'b1;
        old_idx   <= idx;
        old_age   <= age[idx];
      end
      idx <= idx + 1'b1;
    end
  end

  // Voice table and controller state update on COMMIT
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gate       <= '0;
      held       <= '0;
      trig       <= '0;
      SUSTAIN    <= 1'b0;
      STEAL_CNT  <= '0;
      PITCH_BEND <= 14'h2000;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note[v] <= '0;
        vel[v]  <= '0;
        age[v]  <= '0;
      end
    end else begin
      trig <= '0;
      if (state == COMMIT) begin
        if (is_on) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (IDX_W'(v) == tgt) begin
              gate[v] <= 1'b1;
              held[v] <= 1'b0;
              note[v] <= d1[6:0];
              vel[v]  <= d2[6:0];
              age[v]  <= '0;
              trig[v] <= 1'b1;
            end else if (gate[v] && age[v] != AGE_MAX) begin
              age[v] <= age[v] + 1'b1;
            end
          end
          if (steal && STEAL_CNT != 8'hFF) STEAL_CNT <= STEAL_CNT + 1'b1;
        end else if (is_off) begin
          if (match_found) begin
            if (SUSTAIN) held[match_idx] <= 1'b1;
            else         gate[match_idx] <= 1'b0;
          end
        end else if (is_cc) begin
          if (d1 == 8'd64) begin
            SUSTAIN <= sus_new;
            if (SUSTAIN && !sus_new) begin
              gate <= gate & ~held;
              held <= '0;
            end
          end else if (d1 == 8'd123) begin
            gate <= '0;
            held <= '0;
          end
        end else if (is_bend) begin
          PITCH_BEND <= {d2[6:0], d1[6:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Testbench for midi_voice_alloc: directed scenarios plus randomized event
// streams compared against a voice-table reference model.
module tb_midi_voice_alloc;

  localparam int NV      = 4;
  localparam int AGE_MAX = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        channel;
  logic              omni;
  logic [31:0]       evt_data;
  logic              evt_valid;
  logic              evt_ready;
  logic [NV-1:0]     voice_gate;
  logic [7*NV-1:0]   voice_note;
  logic [7*NV-1:0]   voice_vel;
  logic [NV-1:0]     voice_trig;
  logic [13:0]       pitch_bend;
  logic              sustain;
  logic [7:0]        steal_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_gate [NV];
  bit m_held [NV];
  int m_note [NV];
  int m_vel  [NV];
  int m_age  [NV];
  bit m_sus;
  int m_steal;
  int m_bend;
  int m_trig;

  midi_voice_alloc #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .CLK(clk), .RESET_N(rst_n), .CHANNEL(channel), .OMNI(omni),
    .EVT_DATA(evt_data), .EVT_VALID(evt_valid), .EVT_READY(evt_ready),
    .VOICE_GATE(voice_gate), .VOICE_NOTE(voice_note), .VOICE_VEL(voice_vel),
    .VOICE_TRIG(voice_trig), .PITCH_BEND(pitch_bend), .SUSTAIN(sustain),
    .STEAL_CNT(steal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0; m_held[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_age[v] = 0;
    end
    m_sus = 0; m_steal = 0; m_bend = 'h2000; m_trig = 0;
  endtask

  function automatic int find_match(input int n);
    for (int v = 0; v < NV; v++) if (m_gate[v] && m_note[v] == n) return v;
    return -1;
  endfunction

  // Applies one event with the rules of the voice allocator
  task automatic model_apply(input logic [31:0] p);
    int cin = int'(p[27:24]);
    int typ = int'(p[23:20]);
    int ch  = int'(p[19:16]);
    int d1  = int'(p[15:8]);
    int d2  = int'(p[7:0]);
    int t, best;
    m_trig = 0;
    if (!(omni || ch == int'(channel))) return;
    if (cin == 9 && typ == 9 && d2 != 0) begin
      t = find_match(d1 & 127);
      if (t < 0) for (int v = NV - 1; v >= 0; v--) if (!m_gate[v]) t = v;
      if (t < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++) if (best < 0 || m_age[v] > m_age[best]) best = v;
        t = best;
        if (m_steal < 255) m_steal++;
      end
      for (int v = 0; v < NV; v++)
        if (v != t && m_gate[v] && m_age[v] < AGE_MAX) m_age[v]++;
      m_gate[t] = 1; m_held[t] = 0; m_note[t] = d1 & 127; m_vel[t] = d2 & 127; m_age[t] = 0;
      m_trig = 1 << t;
    end else if ((cin == 8 && typ == 8) || (cin == 9 && typ == 9)) begin
      t = find_match(d1 & 127);
      if (t >= 0) begin
        if (m_sus) m_held[t] = 1;
        else       m_gate[t] = 0;
      end
    end else if (cin == 11 && typ == 11) begin
      if (d1 == 64) begin
        if (m_sus && d2 < 64)
          for (int v = 0; v < NV; v++) begin
            if (m_held[v]) m_gate[v] = 0;
            m_held[v] = 0;
          end
        m_sus = (d2 >= 64);
      end else if (d1 == 123) begin
        for (int v = 0; v < NV; v++) begin m_gate[v] = 0; m_held[v] = 0; end
      end
    end else if (cin == 14 && typ == 14) begin
      m_bend = ((d2 & 127) << 7) | (d1 & 127);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NV-1:0]   eg;
    logic [7*NV-1:0] en, ev;
    for (int v = 0; v < NV; v++) begin
      eg[v] = m_gate[v];
      en[7*v +: 7] = 7'(m_note[v]);
      ev[7*v +: 7] = 7'(m_vel[v]);
    end
    chk({tag, ":gate"},  64'(voice_gate), 64'(eg));
    chk({tag, ":note"},  64'(voice_note), 64'(en));
    chk({tag, ":vel"},   64'(voice_vel),  64'(ev));
    chk({tag, ":trig"},  64'(voice_trig), 64'(m_trig));
    chk({tag, ":bend"},  64'(pitch_bend), 64'(m_bend));
    chk({tag, ":sus"},   64'(sustain),    64'(m_sus));
    chk({tag, ":steal"}, 64'(steal_cnt),  64'(m_steal));
  endtask

  // Sends one packet, checks the busy window, the committed state and the trig pulse width
  task automatic send(input string tag, input logic [31:0] p);
    int  lowc = 0;
    bit  early_trig = 0;
    @(negedge clk);
    chk({tag, ":ready_pre"}, 64'(evt_ready), 64'd1);
    evt_data  = p;
    evt_valid = 1'b1;
    @(posedge clk);
    #1;
    evt_valid = 1'b0;
    evt_data  = $urandom;
    model_apply(p);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (evt_ready) break;
      lowc++;
      if (voice_trig != '0) early_trig = 1;
    end
    chk({tag, ":busy_cycles"}, 64'(lowc), 64'(NV + 1));
    chk({tag, ":trig_early"}, 64'(early_trig), 64'd0);
    check_outputs(tag);
    @(negedge clk);
    chk({tag, ":trig_clear"}, 64'(voice_trig), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] mk(input int cin, input int st, input int d1, input int d2);
    return {4'($urandom_range(0, 15)), 4'(cin), 8'(st), 8'(d1), 8'(d2)};
  endfunction

  logic [31:0] rp;
  int          r, ch, nt;

  initial begin
    rst_n = 1'b0; channel = 4'd0; omni = 1'b0; evt_valid = 1'b0; evt_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset:ready", 64'(evt_ready), 64'd1);
    check_outputs("reset");
    rst_n = 1'b1;

    // First note, then fill and steal
    send("on60", 32'h09903C64);
    send("on62", 32'h09903E64);
    send("on64", 32'h09904064);
    send("on65", 32'h09904164);
    send("steal67", 32'h09904364);
    chk("steal67:v0note", 64'(voice_note[6:0]), 64'd67);

    // Velocity-zero note-off, then reuse of the freed voice
    do_reset();
    send("on60b", 32'h09903C64);
    send("vel0off", 32'h09903C00);
    send("reon60", 32'h09903C50);

    // Sustain hold and release
    do_reset();
    send("sus_on", 32'h0BB0407F);
    send("sus_note", 32'h09903C64);
    send("sus_off_note", 32'h08803C40);
    send("sus_release", 32'h0BB04000);

    // Pitch bend and channel filtering
    send("bend", 32'h0EE07F7F);
    chk("bend:max", 64'(pitch_bend), 64'h3FFF);
    send("ch5_filtered", 32'h09953C64);
    omni = 1'b1;
    send("ch5_omni", 32'h09953C64);
    omni = 1'b0;
    send("all_off", 32'h0BB07B00);

    // Age saturation decides the steal victim
    do_reset();
    send("age_a", 32'h09903C64);
    send("age_b", 32'h09903D64);
    for (int i = 0; i < 14; i++) send("age_retrig", 32'h09903C64);
    send("age_c", 32'h09903E64);
    send("age_d", 32'h09903F64);
    send("age_steal", 32'h09904064);

    // Steal counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) send("satsteal", mk(9, 'h90, 10 + (i % 100), 99));
    chk("satsteal:cnt", 64'(steal_cnt), 64'd255);

    // Reset during SCAN discards the event
    do_reset();
    send("pre_mid", 32'h0EE00010);
    @(negedge clk);
    evt_data = 32'h09904564; evt_valid = 1'b1;
    @(posedge clk);
    #1 evt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset:ready", 64'(evt_ready), 64'd1);
    chk("midreset:gate", 64'(voice_gate), 64'd0);
    chk("midreset:bend", 64'(pitch_bend), 64'h2000);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midreset:ready_after", 64'(evt_ready), 64'd1);
    check_outputs("midreset");

    // Randomized event stream
    channel = 4'd3;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) omni = ~omni;
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 3;
      nt = 60 + int'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 19));
      if (r < 8)       rp = mk(9, 'h90 | ch, nt, int'($urandom_range(1, 127)));
      else if (r < 10) rp = mk(9, 'h90 | ch, nt, 0);
      else if (r < 14) rp = mk(8, 'h80 | ch, nt, int'($urandom_range(0, 127)));
      else if (r < 16) rp = mk(11, 'hB0 | ch, 64, ($urandom_range(0, 1) != 0) ? 64 : 63);
      else if (r == 16) rp = mk(11, 'hB0 | ch, 123, 0);
      else if (r == 17) rp = mk(14, 'hE0 | ch, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      else if (r == 18) rp = mk(9, 'h80 | ch, nt, 50);
      else              rp = mk(10, 'hA0 | ch, nt, 50);
      send("rand", rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Sits directly upstream of the synth sample generator. Consumes 32-bit USB-MIDI event packets that the NIOS USB host software pushes through a valid/ready port.
- Decodes note-on, note-off, sustain, all-notes-off and pitch-bend events.
- Maintains a polyphonic voice table with oldest-voice stealing, and drives per-voice gate/note/velocity/trigger to the synth.
- Runs entirely in the synth clock domain (CLK).

Parameters:
- NUM_VOICES, 4, number of voice slots (2..8).
- AGE_W, 4, width of per-voice saturating age counter.

Ports:
- CLK  in  1  synth clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CHANNEL  in  4  MIDI channel to accept (0..15).
- OMNI  in  1  1 = accept all channels, ignore CHANNEL.
- EVT_DATA  in  32  packet: [31:24] cable/CIN header, [23:16] status, [15:8] data1, [7:0] data2.
- EVT_VALID  in  1  packet valid.
- EVT_READY  out  1  block can accept a packet.
- VOICE_GATE  out  NUM_VOICES  per-voice gate.
- VOICE_NOTE  out  7*NUM_VOICES  per-voice MIDI note; voice v at [7v+6:7v].
- VOICE_VEL  out  7*NUM_VOICES  per-voice velocity, same packing.
- VOICE_TRIG  out  NUM_VOICES  one-cycle pulse when a voice is (re)triggered.
- PITCH_BEND  out  14  latest bend value; 0x2000 = centre.
- SUSTAIN  out  1  sustain pedal state.
- STEAL_CNT  out  8  saturating count of voice steals.

Behaviour:
- Reset (async, RESET_N=0): FSM to IDLE; all of the following cleared:
  - gates, notes, velocities, trig, held flags, ages, STEAL_CNT, SUSTAIN;
  - PITCH_BEND=0x2000.
  - EVT_READY = (state==IDLE), so it reads 1 during reset.
  - Reset mid-scan discards the in-flight event.
- Handshake: accept on the edge where EVT_VALID && EVT_READY. The packet is latched; EVT_READY drops next cycle. EVT_DATA is don't-care while EVT_READY=0.
- FSM: IDLE -> SCAN (NUM_VOICES cycles, index 0..N-1) -> COMMIT (1 cycle) -> IDLE.
  - If accepted at edge k, COMMIT updates outputs at edge k+N+1 and EVT_READY is 1 again after that edge.
  - Throughput: one event per N+2 cycles.
- Decode, using CIN = header[3:0] and status type = status[7:4]. Channel match = OMNI or status[3:0]==CHANNEL. Non-matching or unknown events still pass through SCAN/COMMIT with no state change.
  - Note-on: CIN 0x9 and type 0x9 and data2!=0.
  - Note-off: CIN 0x8 and type 0x8, or note-on with data2==0.
  - CC: CIN 0xB, type 0xB.
    - data1=64: SUSTAIN=(data2>=64). On a 1->0 transition, clear gate of all held voices.
    - data1=123: clear all gates and held flags.
  - Pitch bend: CIN 0xE, type 0xE. PITCH_BEND={data2[6:0],data1[6:0]}.
- SCAN records, lowest index winning ties:
  - the match voice (gated and note==data1);
  - the first free voice (gate=0);
  - the oldest gated voice (max age).
- COMMIT for note-on, target chosen in this priority:
  - match (retrigger);
  - else free voice;
  - else oldest voice (steal; STEAL_CNT += 1, saturating at 255).
  - Target gets note, velocity, gate=1, held=0, age=0, and TRIG pulses for exactly that COMMIT cycle.
  - Every other gated voice age += 1, saturating at 2^AGE_W-1.
- COMMIT for note-off:
  - match with SUSTAIN=1: held=1, gate stays 1.
  - match with SUSTAIN=0: gate=0.
  - no match: no change.
- Note/velocity registers retain their last values when gate=0.
- VOICE_TRIG is 0 in all cycles except COMMIT of a note-on.

Test Plan:
- Reset release, then note-on ch0 note 60 vel 100 (EVT_DATA=0x09903C64), CHANNEL=0 -> at edge k+5 (N=4): voice0 gate=1, note=60, vel=100; TRIG[0] one cycle; EVT_READY low for exactly 5 cycles.
- Note-ons 60,62,64,65,67 with no note-offs -> note 67 steals voice0 (oldest); STEAL_CNT=1; TRIG[0] pulses; voices1-3 unchanged.
- Note-on 60, then 0x09903C00 (vel 0) -> voice0 gate=0, note stays 60; second note-on 60 vel 80 reuses voice0, vel=80.
- CC64=127, note-on 60, note-off 60 -> gate stays 1; CC64=0 -> gate 0 at that COMMIT; SUSTAIN follows 1->0.
- Pitch bend 0x0EE07F7F -> PITCH_BEND=0x3FFF. Note-on on ch5 with CHANNEL=0, OMNI=0 -> no change; same packet with OMNI=1 -> voice allocated.
- Assert RESET_N low during SCAN of a note-on -> no voice gated after release, EVT_READY=1, PITCH_BEND=0x2000.
